// File: rtl/spi_slave_rx_if.sv
// Pin and consumer-side bundle for the dual-lane SPI slave receiver.
// The slave modport is the receiver's view; the master modport is the board/consumer view.
interface spi_slave_rx_if #(
  parameter int unsigned FRAME_BITS = 8
);
  logic                  SPISCLKI;
  logic                  SPISSI;
  logic                  SPISDI_0;
  logic                  SPISDI_1;
  logic                  SPISDO_S;
  logic                  rx_ack;
  logic [FRAME_BITS-1:0] data_0;
  logic [FRAME_BITS-1:0] data_1;
  logic                  rx_avail;
  logic                  rx_overrun;
  logic                  rx_frame_err;

  modport slave (
    input  SPISCLKI, SPISSI, SPISDI_0, SPISDI_1, rx_ack,
    output SPISDO_S, data_0, data_1, rx_avail, rx_overrun, rx_frame_err
  );

  modport master (
    output SPISCLKI, SPISSI, SPISDI_0, SPISDI_1, rx_ack,
    input  SPISDO_S, data_0, data_1, rx_avail, rx_overrun, rx_frame_err
  );
endinterface

// File: rtl/spi_slave_rx.sv
// Dual-lane SPI mode-0 slave receiver, oversampled in the PCLK domain, with a valid/ack holding
// register. Optional echo of the held lane 0 word on SPISDO_S when SPI_SLAVE_ECHO_EN is defined.
module spi_slave_rx #(
  parameter int unsigned FRAME_BITS = 8
) (
  input  logic           PCLK,
  input  logic           PRESET,
  spi_slave_rx_if.slave  bus
);

  localparam int unsigned CntW = $clog2(FRAME_BITS + 1);

  typedef enum logic {StIdle, StActive} state_e;

  logic [2:0] sclk_sync_q, ss_sync_q;
  logic [1:0] sdi0_sync_q, sdi1_sync_q;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [FRAME_BITS-1:0] sh0_q, sh1_q;
  logic                  frame_done_q, frame_err_q;

  logic [FRAME_BITS-1:0] data_0_q, data_1_q;
  logic                  avail_q, overrun_q, frame_err_out_q;

  logic            sclk_rise, ss_fall, ss_rise;
  logic [CntW-1:0] cnt_inc, cnt_after;
  logic            bit_done;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      sdi0_sync_q <= '0;
      sdi1_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], bus.SPISCLKI};
      ss_sync_q   <= {ss_sync_q[1:0], bus.SPISSI};
      sdi0_sync_q <= {sdi0_sync_q[0], bus.SPISDI_0};
      sdi1_sync_q <= {sdi1_sync_q[0], bus.SPISDI_1};
    end
  end

  always_comb begin
    sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    cnt_inc   = cnt_q + CntW'(1);
    bit_done  = sclk_rise && (cnt_inc == CntW'(FRAME_BITS));
    // Counter value after this cycle's shift; the abort check uses it when SS rises together
    // with the final SCLK edge.
    if (!sclk_rise) begin
      cnt_after = cnt_q;
    end else if (bit_done) begin
      cnt_after = '0;
    end else begin
      cnt_after = cnt_inc;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sh0_q        <= '0;
      sh1_q        <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_q <= StActive;
            cnt_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
          end
        end
        StActive: begin
          if (sclk_rise) begin
            sh0_q        <= {sh0_q[FRAME_BITS-2:0], sdi0_sync_q[1]};
            sh1_q        <= {sh1_q[FRAME_BITS-2:0], sdi1_sync_q[1]};
            frame_done_q <= bit_done;
          end
          cnt_q <= cnt_after;
          if (ss_rise) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            frame_err_q <= (cnt_after != '0);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      data_0_q        <= '0;
      data_1_q        <= '0;
      avail_q         <= 1'b0;
      overrun_q       <= 1'b0;
      frame_err_out_q <= 1'b0;
    end else begin
      frame_err_out_q <= frame_err_q;
      if (frame_done_q) begin
        if (!avail_q || bus.rx_ack) begin
          data_0_q  <= sh0_q;
          data_1_q  <= sh1_q;
          avail_q   <= 1'b1;
          overrun_q <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (bus.rx_ack && avail_q) begin
        avail_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.data_0       = data_0_q;
  assign bus.data_1       = data_1_q;
  assign bus.rx_avail     = avail_q;
  assign bus.rx_overrun   = overrun_q;
  assign bus.rx_frame_err = frame_err_out_q;

`ifdef SPI_SLAVE_ECHO_EN
  logic [FRAME_BITS-1:0] tx_q;
  logic                  sclk_fall;

  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_q <= '0;
    end else if ((state_q == StIdle && ss_fall) || frame_done_q) begin
      tx_q <= data_0_q;
    end else if (state_q == StActive && sclk_fall) begin
      tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign bus.SPISDO_S = (state_q == StActive) ? tx_q[FRAME_BITS-1] : 1'b0;
`else
  assign bus.SPISDO_S = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: single frame, latency, overrun, abort, back-to-back with
// simultaneous ack, and mid-stream reset.
module tb_spi_slave_rx;
  localparam int unsigned FB = 8;

  logic pclk;
  logic preset;
  int   n_checks;
  int   n_errors;
  int   err_seen;

  spi_slave_rx_if #(.FRAME_BITS(FB)) bus ();

  spi_slave_rx #(.FRAME_BITS(FB)) dut (
    .PCLK   (pclk),
    .PRESET (preset),
    .bus    (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) if (bus.rx_frame_err === 1'b1) err_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: plain; 1: pulse rx_ack in the frame_done cycle of the last bit;
  // 2: check rx_avail rises exactly 3 PCLK edges after the last SCLK rise is sampled.
  task automatic spi_bits(input logic [FB-1:0] w0, input logic [FB-1:0] w1, input int nbits,
                          input int mode);
    for (int i = 0; i < nbits; i++) begin
      @(negedge pclk);
      bus.SPISDI_0 = w0[FB-1-i];
      bus.SPISDI_1 = w1[FB-1-i];
      repeat (3) @(negedge pclk);
      bus.SPISCLKI = 1'b1;
      if (i == nbits - 1 && mode == 1) begin
        repeat (3) @(negedge pclk);
        bus.rx_ack = 1'b1;
        @(negedge pclk);
        bus.rx_ack = 1'b0;
      end else if (i == nbits - 1 && mode == 2) begin
        repeat (3) @(negedge pclk);
        check_eq("avail_before_n3", bus.rx_avail, 0);
        @(negedge pclk);
        check_eq("avail_after_n3", bus.rx_avail, 1);
      end else begin
        repeat (4) @(negedge pclk);
      end
      bus.SPISCLKI = 1'b0;
    end
  endtask

  task automatic select_on();
    @(negedge pclk);
    bus.SPISSI = 1'b0;
    repeat (4) @(negedge pclk);
  endtask

  task automatic select_off();
    repeat (4) @(negedge pclk);
    bus.SPISSI = 1'b1;
    repeat (10) @(negedge pclk);
  endtask

  task automatic frame(input logic [FB-1:0] w0, input logic [FB-1:0] w1);
    select_on();
    spi_bits(w0, w1, FB, 0);
    select_off();
  endtask

  task automatic ack_pulse();
    @(negedge pclk);
    bus.rx_ack = 1'b1;
    @(negedge pclk);
    bus.rx_ack = 1'b0;
  endtask

  initial begin
    logic [5:0] err_pat;
    n_checks = 0;
    n_errors = 0;
    err_seen = 0;
    preset       = 1'b1;
    bus.SPISCLKI = 1'b0;
    bus.SPISSI   = 1'b1;
    bus.SPISDI_0 = 1'b0;
    bus.SPISDI_1 = 1'b0;
    bus.rx_ack   = 1'b0;
    repeat (4) @(negedge pclk);
    preset = 1'b0;
    repeat (4) @(negedge pclk);
    check_eq("rst_data_0", bus.data_0, 0);
    check_eq("rst_data_1", bus.data_1, 0);
    check_eq("rst_avail", bus.rx_avail, 0);
    check_eq("rst_overrun", bus.rx_overrun, 0);
    check_eq("rst_frame_err", bus.rx_frame_err, 0);
    check_eq("rst_sdo", bus.SPISDO_S, 0);

    // Single frame with exact latency, then ack
    select_on();
    spi_bits(8'h32, 8'h45, FB, 2);
    check_eq("single_sdo_active", bus.SPISDO_S, 0);
    select_off();
    check_eq("single_data_0", bus.data_0, 32'h32);
    check_eq("single_data_1", bus.data_1, 32'h45);
    check_eq("single_overrun", bus.rx_overrun, 0);
    ack_pulse();
    check_eq("single_ack_avail", bus.rx_avail, 0);
    check_eq("single_ack_data", bus.data_0, 32'h32);

    // Overrun
    frame(8'hAB, 8'hCD);
    frame(8'hFF, 8'h97);
    check_eq("ovr_data_0", bus.data_0, 32'hAB);
    check_eq("ovr_data_1", bus.data_1, 32'hCD);
    check_eq("ovr_avail", bus.rx_avail, 1);
    check_eq("ovr_flag", bus.rx_overrun, 1);
    ack_pulse();
    check_eq("ovr_ack_avail", bus.rx_avail, 0);
    check_eq("ovr_ack_flag", bus.rx_overrun, 0);

    // Abort after 5 bits: one-cycle error pulse 3 edges after SS rise is first sampled
    select_on();
    spi_bits(8'h64, 8'h00, 5, 0);
    repeat (4) @(negedge pclk);
    bus.SPISSI = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      err_pat[i] = bus.rx_frame_err;
    end
    check_eq("abort_err_pulse", err_pat, 6'b001000);
    check_eq("abort_avail", bus.rx_avail, 0);
    repeat (6) @(negedge pclk);
    frame(8'h36, 8'h78);
    check_eq("abort_next_0", bus.data_0, 32'h36);
    check_eq("abort_next_1", bus.data_1, 32'h78);
    check_eq("abort_next_avail", bus.rx_avail, 1);
    ack_pulse();

    // Back-to-back frames in one window; ack coincides with the second frame_done
    select_on();
    spi_bits(8'h38, 8'h96, FB, 2);
    check_eq("b2b_first_0", bus.data_0, 32'h38);
    check_eq("b2b_first_1", bus.data_1, 32'h96);
    spi_bits(8'hA8, 8'hC4, FB, 1);
    select_off();
    check_eq("b2b_data_0", bus.data_0, 32'hA8);
    check_eq("b2b_data_1", bus.data_1, 32'hC4);
    check_eq("b2b_avail", bus.rx_avail, 1);
    check_eq("b2b_overrun", bus.rx_overrun, 0);
    check_eq("err_count_mid", err_seen, 1);

    // Reset mid-frame discards everything, no error pulse
    select_on();
    spi_bits(8'hFF, 8'hFF, 3, 0);
    preset = 1'b1;
    repeat (5) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    check_eq("mrst_data_0", bus.data_0, 0);
    check_eq("mrst_data_1", bus.data_1, 0);
    check_eq("mrst_avail", bus.rx_avail, 0);
    check_eq("mrst_overrun", bus.rx_overrun, 0);
    bus.SPISSI = 1'b1;
    repeat (8) @(negedge pclk);
    frame(8'h32, 8'h45);
    check_eq("mrst_next_0", bus.data_0, 32'h32);
    check_eq("mrst_next_1", bus.data_1, 32'h45);
    check_eq("mrst_next_avail", bus.rx_avail, 1);
    check_eq("err_count_end", err_seen, 1);
    check_eq("end_sdo", bus.SPISDO_S, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
